nco_phase_acc: RTL and testbench

- Numerically controlled oscillator core. It consumes the 32-bit frequency tuning word produced by the NCO frequency-select logic.
- Accumulates phase at the system clock (50 MHz; tuning word 85 ≈ 1 Hz). Outputs a truncated phase for the sine LUT, a square wave and a wrap strobe.
- Tuning-word changes are taken through a load/busy handshake. They can be applied at a phase wrap so the waveform stays phase-continuous and glitch-free.

---
 rtl/nco_phase_acc.sv | 143 ++++++++++++++
 tb/tb_nco_phase_acc.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/nco_phase_acc.sv
// Phase accumulator NCO with a load/busy tuning-word handshake and optional
// wrap-synchronous word update. Define NCO_DITHER_EN to add LFSR phase dither.
module nco_phase_acc #(
    parameter int               ACC_W          = 32,
    parameter int               PHASE_W        = 10,
    parameter bit               UPDATE_ON_WRAP = 1'b1,
    parameter logic [ACC_W-1:0] RESET_TW       = '0
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ce,
    input  logic               phase_clr,
    input  logic [ACC_W-1:0]   tw_in,
    input  logic               tw_load,
    output logic               tw_busy,
    output logic [ACC_W-1:0]   tw_active,
    output logic [PHASE_W-1:0] phase_out,
    output logic               sq_out,
    output logic               wrap
);

    typedef enum logic {
        IDLE,
        PENDING
    } state_t;

    state_t             state_q;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [ACC_W-1:0]   tw_active_q;
    logic [ACC_W-1:0]   tw_pend_q;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               sq_q, sq_d;
    logic               wrap_q, wrap_d;
    logic [ACC_W:0]     sum;
    logic               apply_now;

    assign sum = {1'b0, acc_q} + {1'b0, tw_active_q};

    // A phase clear is always a legal update point, even in wrap-synchronous mode.
    always_comb begin
        apply_now = 1'b0;
        if (state_q == PENDING) begin
            if (phase_clr)
                apply_now = 1'b1;
            else if (UPDATE_ON_WRAP)
                apply_now = ce & sum[ACC_W];
            else
                apply_now = 1'b1;
        end
    end

    always_comb begin
        acc_d  = acc_q;
        wrap_d = 1'b0;
        if (phase_clr) begin
            acc_d = '0;
        end else if (ce) begin
            acc_d  = sum[ACC_W-1:0];
            wrap_d = sum[ACC_W];
        end
    end

`ifdef NCO_DITHER_EN
    localparam int         DITH_W    = (ACC_W - PHASE_W > 16) ? 16 : (ACC_W - PHASE_W);
    localparam logic [15:0] DITH_MASK = 16'hFFFF >> (16 - DITH_W);

    logic [15:0]      lfsr_q, lfsr_d;
    logic [ACC_W-1:0] dith_sum;

    always_comb begin
        lfsr_d = lfsr_q;
        if (ce)
            lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end

    assign dith_sum = acc_q + ACC_W'(lfsr_q & DITH_MASK);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            lfsr_q <= 16'hACE1;
        else
            lfsr_q <= lfsr_d;
    end

    always_comb begin
        phase_d = dith_sum[ACC_W-1 -: PHASE_W];
        sq_d    = acc_q[ACC_W-1];
    end
`else
    always_comb begin
        phase_d = acc_q[ACC_W-1 -: PHASE_W];
        sq_d    = acc_q[ACC_W-1];
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q   <= '0;
            phase_q <= '0;
            sq_q    <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            phase_q <= phase_d;
            sq_q    <= sq_d;
            wrap_q  <= wrap_d;
        end
    end

    // A load arriving on the apply edge becomes the next pending word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            tw_active_q <= RESET_TW;
            tw_pend_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (tw_load) begin
                        tw_pend_q <= tw_in;
                        state_q   <= PENDING;
                    end
                end
                PENDING: begin
                    if (apply_now)
                        tw_active_q <= tw_pend_q;
                    if (tw_load)
                        tw_pend_q <= tw_in;
                    else if (apply_now)
                        state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign tw_busy   = (state_q == PENDING);
    assign tw_active = tw_active_q;
    assign phase_out = phase_q;
    assign sq_out    = sq_q;
    assign wrap      = wrap_q;

endmodule

// File: tb/tb_nco_phase_acc.sv
// Directed bench for nco_phase_acc: one wrap-synchronous instance and one
// immediate-update instance share clock, reset, ce and phase_clr.
module tb_nco_phase_acc;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        ce;
    logic        phase_clr;
    logic [31:0] tw_in1, tw_in0;
    logic        tw_load1, tw_load0;

    logic        busy1, busy0;
    logic [31:0] twact1, twact0;
    logic [9:0]  phase1, phase0;
    logic        sq1, sq0;
    logic        wrap1, wrap0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    nco_phase_acc #(.ACC_W(32), .PHASE_W(10), .UPDATE_ON_WRAP(1'b1), .RESET_TW(32'h0)) dutWrap (
        .clk(clk), .reset_n(reset_n), .ce(ce), .phase_clr(phase_clr),
        .tw_in(tw_in1), .tw_load(tw_load1), .tw_busy(busy1), .tw_active(twact1),
        .phase_out(phase1), .sq_out(sq1), .wrap(wrap1)
    );

    nco_phase_acc #(.ACC_W(32), .PHASE_W(10), .UPDATE_ON_WRAP(1'b0), .RESET_TW(32'h0)) dutImm (
        .clk(clk), .reset_n(reset_n), .ce(ce), .phase_clr(phase_clr),
        .tw_in(tw_in0), .tw_load(tw_load0), .tw_busy(busy0), .tw_active(twact0),
        .phase_out(phase0), .sq_out(sq0), .wrap(wrap0)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive inputs now; they are sampled at the next rising edge, outputs
    // are then examined at the following falling edge.
    task automatic applyStimulus(input logic ceV, input logic clrV,
                                 input logic ld1V, input logic [31:0] tw1V,
                                 input logic ld0V, input logic [31:0] tw0V);
        ce        = ceV;
        phase_clr = clrV;
        tw_load1  = ld1V;
        tw_in1    = tw1V;
        tw_load0  = ld0V;
        tw_in0    = tw0V;
        @(negedge clk);
    endtask

    initial begin
        reset_n = 1'b0;
        ce = 1'b0; phase_clr = 1'b0;
        tw_in1 = '0; tw_load1 = 1'b0; tw_in0 = '0; tw_load0 = 1'b0;
        @(negedge clk);
        checkOutput("rst_phase", phase1, 0);
        checkOutput("rst_sq", sq1, 0);
        checkOutput("rst_wrap", wrap1, 0);
        checkOutput("rst_busy", busy1, 0);
        checkOutput("rst_twact", twact1, 32'h0);
        checkOutput("rst_busy0", busy0, 0);
        reset_n = 1'b1;

        // Load 0x40000000 (wrap mode needs a clear since tw_active=0) and 85 (immediate mode)
        applyStimulus(1, 0, 1, 32'h4000_0000, 1, 32'd85);
        checkOutput("ld_busy1", busy1, 1);
        checkOutput("ld_twact1_old", twact1, 32'h0);
        checkOutput("ld_busy0", busy0, 1);
        checkOutput("ld_twact0_old", twact0, 32'h0);

        // Clear applies the wrap-mode word; immediate mode applies 85 while taking 100
        applyStimulus(1, 1, 0, 32'h0, 1, 32'd100);
        checkOutput("clr_twact1", twact1, 32'h4000_0000);
        checkOutput("clr_busy1", busy1, 0);
        checkOutput("imm_twact0", twact0, 32'd85);
        checkOutput("imm_busy0_reload", busy0, 1);

        for (int k = 3; k <= 10; k++) begin
            applyStimulus(1, 0, 0, 32'h0, 0, 32'h0);
            checkOutput("quad_phase", phase1, ((k - 3) % 4) * 256);
            checkOutput("quad_sq", sq1, (((k - 3) % 4) >= 2) ? 1 : 0);
            checkOutput("quad_wrap", wrap1, ((k % 4) == 2) ? 1 : 0);
        end
        checkOutput("imm_twact0_second", twact0, 32'd100);
        checkOutput("imm_busy0_idle", busy0, 0);

        // Load 0x20000000 while acc=0x40000000; it applies on the wrap edge
        applyStimulus(1, 0, 0, 32'h0, 0, 32'h0);
        applyStimulus(1, 0, 1, 32'h2000_0000, 0, 32'h0);
        checkOutput("wrap_ld_busy_a", busy1, 1);
        applyStimulus(1, 0, 0, 32'h0, 0, 32'h0);
        checkOutput("wrap_ld_busy_b", busy1, 1);
        checkOutput("wrap_ld_twact_old", twact1, 32'h4000_0000);
        applyStimulus(1, 0, 0, 32'h0, 0, 32'h0);
        checkOutput("wrap_ld_busy_done", busy1, 0);
        checkOutput("wrap_ld_twact_new", twact1, 32'h2000_0000);
        checkOutput("wrap_ld_wrap", wrap1, 1);
        applyStimulus(1, 0, 0, 32'h0, 0, 32'h0);
        checkOutput("step128_a", phase1, 0);
        applyStimulus(1, 0, 0, 32'h0, 0, 32'h0);
        checkOutput("step128_b", phase1, 128);
        applyStimulus(1, 0, 0, 32'h0, 0, 32'h0);
        checkOutput("step128_c", phase1, 256);

        // Freeze with acc=0x60000000
        for (int k = 0; k < 10; k++) begin
            applyStimulus(0, 0, 0, 32'h0, 0, 32'h0);
            checkOutput("frz_phase", phase1, 384);
            checkOutput("frz_sq", sq1, 0);
            checkOutput("frz_wrap", wrap1, 0);
        end
        applyStimulus(1, 0, 0, 32'h0, 0, 32'h0);
        checkOutput("resume_phase", phase1, 384);
        applyStimulus(1, 0, 0, 32'h0, 0, 32'h0);
        checkOutput("resume_phase2", phase1, 512);
        checkOutput("resume_sq", sq1, 1);

        // Two loads while pending: last write wins at the wrap
        applyStimulus(1, 0, 1, 32'd12887, 0, 32'h0);
        checkOutput("ovw_busy_a", busy1, 1);
        applyStimulus(1, 0, 1, 32'd171799, 0, 32'h0);
        checkOutput("ovw_busy_b", busy1, 1);
        checkOutput("ovw_twact_old", twact1, 32'h2000_0000);
        applyStimulus(1, 0, 0, 32'h0, 0, 32'h0);
        checkOutput("ovw_busy_done", busy1, 0);
        checkOutput("ovw_twact", twact1, 32'd171799);
        checkOutput("ovw_wrap", wrap1, 1);

        // Pending word applied by phase_clr rather than a carry
        applyStimulus(1, 0, 1, 32'h1000_0000, 0, 32'h0);
        applyStimulus(1, 0, 0, 32'h0, 0, 32'h0);
        checkOutput("pclr_busy_wait", busy1, 1);
        applyStimulus(1, 1, 0, 32'h0, 0, 32'h0);
        checkOutput("pclr_busy", busy1, 0);
        checkOutput("pclr_twact", twact1, 32'h1000_0000);
        checkOutput("pclr_wrap", wrap1, 0);
        applyStimulus(1, 0, 0, 32'h0, 0, 32'h0);
        checkOutput("pclr_phase_a", phase1, 0);
        applyStimulus(1, 0, 0, 32'h0, 0, 32'h0);
        checkOutput("pclr_phase_b", phase1, 64);
        applyStimulus(1, 0, 0, 32'h0, 0, 32'h0);
        checkOutput("pclr_phase_c", phase1, 128);

        // Clear from acc=0x30000000 with ce still high
        applyStimulus(1, 1, 0, 32'h0, 0, 32'h0);
        checkOutput("clr_phase_lag", phase1, 192);
        checkOutput("clr_wrap", wrap1, 0);
        applyStimulus(1, 0, 0, 32'h0, 0, 32'h0);
        checkOutput("clr_phase_zero", phase1, 0);
        applyStimulus(1, 0, 0, 32'h0, 0, 32'h0);
        checkOutput("clr_phase_restart", phase1, 64);

        // Asynchronous reset while a word is pending
        applyStimulus(1, 0, 1, 32'h0000_5555, 0, 32'h0);
        checkOutput("prerst_busy", busy1, 1);
        checkOutput("prerst_phase", phase1, 128);
        reset_n = 1'b0;
        #1;
        checkOutput("arst_busy", busy1, 0);
        checkOutput("arst_twact", twact1, 32'h0);
        checkOutput("arst_phase", phase1, 0);
        checkOutput("arst_sq", sq1, 0);
        checkOutput("arst_wrap", wrap1, 0);
        checkOutput("arst_twact0", twact0, 32'h0);
        #2;
        reset_n = 1'b1;
        applyStimulus(1, 0, 0, 32'h0, 0, 32'h0);
        checkOutput("postrst_busy", busy1, 0);
        checkOutput("postrst_twact", twact1, 32'h0);
        checkOutput("postrst_phase", phase1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
